// File: rtl/fa_self_test_pkg.sv
// Shared types, constants and the full-adder golden function for the BIST engine.
package fa_test_pkg;

  localparam int FA_NUM_VECTORS = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fa_state_e;

  // Verdict of a run. Held between runs and cleared by the next start.
  typedef struct packed {
    logic       pass;
    logic [7:0] err_count;
    logic       fail_valid;
    logic [2:0] fail_vec;
  } fa_status_t;

  // Returns {carry, sum} for the input vector {a, b, c}.
  function automatic logic [1:0] fa_expected(input logic [2:0] v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/fa_self_test_if.sv
// Bundle between the self-test engine and its wrapper: control, verdict and adder pins.
interface fa_self_test_if;
  logic       start;
  logic       dut_carry;
  logic       dut_sum;
  logic       dut_a;
  logic       dut_b;
  logic       dut_c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic       fail_valid;
  logic [2:0] fail_vec;

  // Wrapper side: launches runs and returns the adder outputs.
  modport master (
    output start, dut_carry, dut_sum,
    input  dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_valid, fail_vec
  );

  // Engine side.
  modport slave (
    input  start, dut_carry, dut_sum,
    output dut_a, dut_b, dut_c, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/fa_self_test_golden.sv
// Combinational reference for the adder under test; kept separate so it can be swapped.
module fa_golden_model
  import fa_test_pkg::*;
(
  input  logic [2:0] vec,
  output logic [1:0] exp_cs
);

  // {carry, sum} expected for the vector currently driven
  always_comb exp_cs = fa_expected(vec);

endmodule

// File: rtl/fa_self_test.sv
// Built-in self-test engine for a full-adder cell: sweeps all eight input
// combinations, samples after a settle window and reports a verdict.
module fa_self_test
  import fa_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input logic          clk,
  input logic          rst,
  fa_self_test_if.slave bus
);

  localparam logic [0:0] S_IDLE    = IDLE;
  localparam logic [0:0] S_RUN     = RUN;
  localparam logic [3:0] HOLD_LAST = 4'(SETTLE_CYCLES);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);
  localparam logic [2:0] VEC_LAST  = 3'(FA_NUM_VECTORS - 1);

  logic [0:0] state;
  logic [2:0] vec;
  logic [3:0] hold;
  logic [7:0] pcnt;
  logic       done_q;
  fa_status_t st;

  logic [1:0] exp_cs;
  logic       sample;
  logic       mism;
  logic       last_vec;
  logic       run_end;
  logic [7:0] err_nxt;

  fa_golden_model u_gold (
    .vec    (vec),
    .exp_cs (exp_cs)
  );

  // Sample/compare decode. The hold counter counts up to the settle length,
  // so the final cycle of a vector's window is the one where it equals it.
  always_comb begin
    sample   = (state == S_RUN) && (hold == HOLD_LAST);
    mism     = ({bus.dut_carry, bus.dut_sum} != exp_cs);
    last_vec = (vec == VEC_LAST);
    run_end  = sample && last_vec && (pcnt == PASS_LAST);
    err_nxt  = (mism && (st.err_count != 8'hFF)) ? st.err_count + 8'd1 : st.err_count;
  end

  // Run sequencer, error accounting and verdict capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      vec    <= 3'd0;
      hold   <= 4'd0;
      pcnt   <= 8'd0;
      done_q <= 1'b0;
      st     <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start) begin
          state         <= S_RUN;
          vec           <= 3'd0;
          hold          <= 4'd0;
          pcnt          <= 8'd0;
          st.err_count  <= 8'd0;
          st.fail_valid <= 1'b0;
          st.pass       <= 1'b0;
        end
      end else if (!sample) begin
        hold <= hold + 4'd1;
      end else begin
        st.err_count <= err_nxt;
        if (mism && !st.fail_valid) begin
          st.fail_valid <= 1'b1;
          st.fail_vec   <= vec;
        end
        hold <= 4'd0;
        vec  <= vec + 3'd1;
        if (last_vec) pcnt <= pcnt + 8'd1;
        // Verdict uses the post-update count so a miss on the last edge counts
        if (run_end) begin
          state   <= S_IDLE;
          done_q  <= 1'b1;
          st.pass <= (err_nxt == 8'd0);
        end
      end
    end
  end

  // Output drive: adder pins park at 000 outside a run
  always_comb begin
    {bus.dut_a, bus.dut_b, bus.dut_c} = (state == S_RUN) ? vec : 3'b000;
    bus.busy       = (state == S_RUN);
    bus.done       = done_q;
    bus.pass       = st.pass;
    bus.err_count  = st.err_count;
    bus.fail_valid = st.fail_valid;
    bus.fail_vec   = st.fail_vec;
  end

endmodule

// File: tb/tb_fa_self_test.sv
// Bench for fa_self_test: three engine configurations, each wired to a table-driven
// model adder whose per-vector responses can be made faulty.
module tb_fa_self_test;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fa_self_test_if if0 ();
  fa_self_test_if if1 ();
  fa_self_test_if if2 ();

  fa_self_test #(.SETTLE_CYCLES(2), .PASSES(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  fa_self_test #(.SETTLE_CYCLES(2), .PASSES(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  fa_self_test #(.SETTLE_CYCLES(0), .PASSES(1)) u2 (.clk(clk), .rst(rst), .bus(if2));

  localparam int SET [3] = '{2, 2, 0};
  localparam int PAS [3] = '{1, 2, 1};

  logic       start_v  [3];
  logic [1:0] resp_tbl [3][8];
  logic       busy_v [3], done_v [3], pass_v [3], fv_v [3];
  logic [7:0] err_v  [3];
  logic [2:0] fvec_v [3], abc_v [3];

  // Model adders plus flattening of the three buses into arrays
  always_comb begin
    if0.start = start_v[0];
    if1.start = start_v[1];
    if2.start = start_v[2];
    {if0.dut_carry, if0.dut_sum} = resp_tbl[0][{if0.dut_a, if0.dut_b, if0.dut_c}];
    {if1.dut_carry, if1.dut_sum} = resp_tbl[1][{if1.dut_a, if1.dut_b, if1.dut_c}];
    {if2.dut_carry, if2.dut_sum} = resp_tbl[2][{if2.dut_a, if2.dut_b, if2.dut_c}];
    busy_v[0] = if0.busy;       busy_v[1] = if1.busy;       busy_v[2] = if2.busy;
    done_v[0] = if0.done;       done_v[1] = if1.done;       done_v[2] = if2.done;
    pass_v[0] = if0.pass;       pass_v[1] = if1.pass;       pass_v[2] = if2.pass;
    fv_v[0]   = if0.fail_valid; fv_v[1]   = if1.fail_valid; fv_v[2]   = if2.fail_valid;
    err_v[0]  = if0.err_count;  err_v[1]  = if1.err_count;  err_v[2]  = if2.err_count;
    fvec_v[0] = if0.fail_vec;   fvec_v[1] = if1.fail_vec;   fvec_v[2] = if2.fail_vec;
    abc_v[0]  = {if0.dut_a, if0.dut_b, if0.dut_c};
    abc_v[1]  = {if1.dut_a, if1.dut_b, if1.dut_c};
    abc_v[2]  = {if2.dut_a, if2.dut_b, if2.dut_c};
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Arithmetic truth: {carry,sum} is simply the count of ones among a,b,c
  function automatic logic [1:0] ones_of(input int v);
    return 2'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1));
  endfunction

  // fault: 0 good adder, 1 sum stuck at 0, 2 carry inverted
  task automatic fill_tbl(input int i, input int fault);
    logic [1:0] g;
    for (int v = 0; v < 8; v++) begin
      g = ones_of(v);
      case (fault)
        1:       resp_tbl[i][v] = {g[1], 1'b0};
        2:       resp_tbl[i][v] = {~g[1], g[0]};
        default: resp_tbl[i][v] = g;
      endcase
    end
  endtask

  task automatic model(input int i, output int cyc, output int err, output logic fv,
                       output logic [2:0] fvec, output logic p);
    int bad = 0;
    fv = 1'b0;
    fvec = 3'd0;
    for (int v = 0; v < 8; v++)
      if (resp_tbl[i][v] != ones_of(v)) begin
        bad++;
        if (!fv) begin fv = 1'b1; fvec = 3'(v); end
      end
    cyc = PAS[i] * 8 * (SET[i] + 1);
    err = PAS[i] * bad;
    if (err > 255) err = 255;
    p = (err == 0);
  endtask

  task automatic rst_vals(input int i, input string tag);
    check({tag, "/abc"},   abc_v[i], 0);
    check({tag, "/busy"},  busy_v[i], 0);
    check({tag, "/done"},  done_v[i], 0);
    check({tag, "/pass"},  pass_v[i], 0);
    check({tag, "/err"},   err_v[i], 0);
    check({tag, "/fv"},    fv_v[i], 0);
    check({tag, "/fvec"},  fvec_v[i], 0);
  endtask

  // Pulse start, count busy cycles until done; leaves the bench one cycle after done.
  task automatic do_run(input int i, output int cyc, output int got, output int busy_at_done,
                        output int dn_next);
    cyc = 0; got = 0; busy_at_done = 1; dn_next = 1;
    @(negedge clk); start_v[i] = 1'b1;
    @(negedge clk); start_v[i] = 1'b0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      if (busy_v[i]) cyc++;
      if (done_v[i]) begin got = 1; busy_at_done = int'(busy_v[i]); end
      else @(negedge clk);
    end
    if (got != 0) begin
      @(negedge clk);
      dn_next = int'(done_v[i]);
    end
  endtask

  task automatic run_and_compare(input int i, input string tag, input int e_cyc, input int e_err,
                                 input logic e_pass, input logic e_fv, input logic [2:0] e_fvec);
    int cyc, got, bad, dn;
    do_run(i, cyc, got, bad, dn);
    check({tag, "/done_seen"}, got, 1);
    check({tag, "/busy_cycles"}, cyc, e_cyc);
    check({tag, "/busy_at_done"}, bad, 0);
    check({tag, "/done_width"}, dn, 0);
    check({tag, "/err"}, err_v[i], e_err);
    check({tag, "/pass"}, pass_v[i], e_pass);
    check({tag, "/fv"}, fv_v[i], e_fv);
    if (e_fv) check({tag, "/fvec"}, fvec_v[i], e_fvec);
  endtask

  typedef struct {
    int         inst;
    int         fault;
    int         e_cyc;
    int         e_err;
    logic       e_pass;
    logic       e_fv;
    logic [2:0] e_fvec;
  } tv_t;

  tv_t tbl [6];

  initial begin
    int cyc, got, err, e_cyc, e_err, dseen;
    logic fv, p;
    logic [2:0] fvec;
    logic [1:0] m;

    for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; fill_tbl(i, 0); end

    tbl[0] = '{0, 0, 24, 0,  1'b1, 1'b0, 3'd0};
    tbl[1] = '{0, 1, 24, 4,  1'b0, 1'b1, 3'b001};
    tbl[2] = '{1, 2, 48, 16, 1'b0, 1'b1, 3'b000};
    tbl[3] = '{2, 0, 8,  0,  1'b1, 1'b0, 3'd0};
    tbl[4] = '{1, 0, 48, 0,  1'b1, 1'b0, 3'd0};
    tbl[5] = '{2, 1, 8,  4,  1'b0, 1'b1, 3'b001};

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_vals(i, $sformatf("rst_hold%0d", i));
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_vals(i, $sformatf("rst_rel%0d", i));

    // Directed table
    for (int t = 0; t < 6; t++) begin
      fill_tbl(tbl[t].inst, tbl[t].fault);
      run_and_compare(tbl[t].inst, $sformatf("tbl%0d", t), tbl[t].e_cyc, tbl[t].e_err,
                      tbl[t].e_pass, tbl[t].e_fv, tbl[t].e_fvec);
    end

    // Zero settle: pins step one vector per cycle
    fill_tbl(2, 0);
    @(negedge clk); start_v[2] = 1'b1;
    @(negedge clk); start_v[2] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("step%0d", k), abc_v[2], k);
      @(negedge clk);
    end
    check("step_done", done_v[2], 1);
    check("step_idle_abc", abc_v[2], 0);
    check("step_pass", pass_v[2], 1);

    // Reset at cycle 5 of a run aborts with no done pulse
    fill_tbl(0, 1);
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy_v[0], 1);
    rst = 1'b1;
    #1;
    rst_vals(0, "abort");
    @(negedge clk);
    rst = 1'b0;
    dseen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_v[0]) dseen++;
    end
    check("abort_no_done", dseen, 0);
    check("abort_idle", busy_v[0], 0);
    fill_tbl(0, 0);
    run_and_compare(0, "after_abort", 24, 0, 1'b1, 1'b0, 3'd0);

    // Mid-run start pulse ignored; held start relaunches after done
    fill_tbl(0, 1);
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    cyc = 0; got = 0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      if (busy_v[0]) cyc++;
      if (cyc == 10) start_v[0] = 1'b1;
      else if (cyc == 11) start_v[0] = 1'b0;
      if (cyc == 20) start_v[0] = 1'b1;
      if (done_v[0]) got = 1;
      else @(negedge clk);
    end
    check("held_done_seen", got, 1);
    check("held_busy_cycles", cyc, 24);
    check("held_err", err_v[0], 4);
    check("held_pass", pass_v[0], 0);
    fill_tbl(0, 0);
    @(negedge clk);
    check("relaunch_busy", busy_v[0], 1);
    check("relaunch_done_low", done_v[0], 0);
    check("relaunch_err_clr", err_v[0], 0);
    check("relaunch_fv_clr", fv_v[0], 0);
    start_v[0] = 1'b0;
    cyc = 1; got = 0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      @(negedge clk);
      if (busy_v[0]) cyc++;
      if (done_v[0]) got = 1;
    end
    check("relaunch_done_seen", got, 1);
    check("relaunch_cycles", cyc, 24);
    check("relaunch_pass", pass_v[0], 1);

    // Random fault patterns against the model
    for (int r = 0; r < 12; r++) begin
      int i;
      i = $urandom_range(0, 2);
      for (int v = 0; v < 8; v++) begin
        m = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        resp_tbl[i][v] = ones_of(v) ^ m;
      end
      model(i, e_cyc, e_err, fv, fvec, p);
      run_and_compare(i, $sformatf("rnd%0d_u%0d", r, i), e_cyc, e_err, p, fv, fvec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fa_self_test.md
# fa_self_test

Synthesizable built-in self-test engine for the `full_adder` cell. It is the checking end of the full-adder stimulus flow: it drives all eight (a, b, c) input combinations into an externally connected full adder and samples `carry` and `sum` after a programmable settle time. It compares each sample against a golden model and reports a pass/fail verdict, an error count and the first failing vector. It sits beside the DUT in a test wrapper and needs no simulator-only constructs.

## Interface
- `SETTLE_CYCLES`, default 2: extra cycles each vector is held before sampling; range 0..15.
- `PASSES`, default 1: number of complete 8-vector sweeps per run; range 1..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: run request, sampled only in IDLE.
- `dut_carry` in 1: carry output of the adder under test.
- `dut_sum` in 1: sum output of the adder under test.
- `dut_a` out 1: drives DUT input a.
- `dut_b` out 1: drives DUT input b.
- `dut_c` out 1: drives DUT input c.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle pulse when a run finishes.
- `pass` out 1: verdict of the last completed run; held until the next start.
- `err_count` out 8: mismatching samples in the last or current run; saturates at 255.
- `fail_valid` out 1: at least one mismatch has occurred in the current or last run.
- `fail_vec` out 3: {a,b,c} of the first mismatch; valid only when `fail_valid` is high.

## Operation
- States: IDLE and RUN. Internal state: vector counter `vec`[2:0], hold counter [3:0], pass counter [7:0].
- Vector mapping: `dut_a`=vec[2], `dut_b`=vec[1], `dut_c`=vec[0]. Sweep order is 000 to 111 ascending.
- Golden model:
  - expected sum = a^b^c.
  - expected carry = (a&b)|(a&c)|(b&c).
  - A mismatch is any difference in either bit. Each vector counts as at most one error.
- IDLE to RUN, on an edge with `start`=1:
  - set `busy`=1;
  - clear vec, hold counter, pass counter, `err_count` and `fail_valid`;
  - clear `pass`.
- RUN, each edge:
  - If hold counter < SETTLE_CYCLES: increment the hold counter and do nothing else.
  - Otherwise:
    - Sample: compare `dut_carry`/`dut_sum` against the golden model.
    - On mismatch: increment `err_count` with saturation. If `fail_valid` is 0, capture `fail_vec`=vec and set `fail_valid`=1.
    - Advance: clear the hold counter. If vec=7, wrap vec to 0 and increment the pass counter; otherwise increment vec.
- Run end: the sample edge of vector 7 in pass PASSES-1 goes to IDLE. On that edge:
  - `busy`=0 and `done`=1;
  - `pass` = 1 if the final error count is zero, including a mismatch detected on that same edge.
- `start` during RUN is ignored.
- Outside RUN, `dut_a/b/c` hold 000.

## Timing
- Reset values: `dut_a/b/c`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_vec`=000. State is IDLE.
- `rst` mid-run aborts immediately to the reset values. No `done` pulse is produced.
- Each vector is driven for exactly SETTLE_CYCLES+1 cycles. The sample is taken at the final edge of that window.
- The DUT is combinational and is allowed the whole hold window to settle.
- Run length: `busy` is high for PASSES×8×(SETTLE_CYCLES+1) cycles.
- `done` rises on the edge where `busy` falls and lasts one cycle.
- `start` held high continuously relaunches a run on the edge after `done`, because the FSM is back in IDLE.

## Structure
- Package `fa_test_pkg`:
  - state enum {IDLE, RUN};
  - function `fa_expected(input [2:0] v)` returning {carry,sum};
  - constant `FA_NUM_VECTORS`=8.
- Sub-module `fa_golden_model`: a combinational wrapper around `fa_expected`, instantiated once so it can be swapped for fault studies.
- The DUT (`full_adder`) is not instantiated inside this block. The test wrapper connects it.

## Test plan
- **Correct `full_adder`, SETTLE_CYCLES=2, PASSES=1, pulse `start`:** expect `busy` high for 24 cycles, `done` pulse, `pass`=1, `err_count`=0, `fail_valid`=0.
- **Fault, `sum` stuck at 0:** expect `err_count`=4, `fail_vec`=001, `pass`=0.
- **Fault, `carry` inverted, PASSES=2:** expect `err_count`=16, `fail_vec`=000, `busy` high for 48 cycles.
- **SETTLE_CYCLES=0:** each vector changes every cycle; expect a 8-cycle run, `pass`=1, and `dut_a/b/c` stepping 000 to 111 on consecutive cycles.
- **Reset and restart:** assert `rst` at cycle 5 of a run; expect all outputs at reset values, no `done`, `dut_a/b/c`=000. A subsequent `start` gives a clean full run.
- **`start` pulsed during RUN and held high after `done`:** the mid-run pulse is ignored and run length is unchanged. The held `start` launches a new run on the edge after `done`, and the new run clears `err_count`.
